// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - multiplexed 4-digit display scan controller
//
// Ports:
//   clk     system clock, all logic on its rising edge
//   rst     synchronous active-high reset
//   run     scan enable (level)
//   mask    digit enable mask, bit i puts digit i in the scan
//   sel     digit select for the 4:1 display mux
//   mux_en  display mux load enable
//   an      active-low anode drive, at most one bit low
//   frame   one-cycle pulse when the scan wraps around
module scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       mux_en,
  output logic [3:0] an,
  output logic       frame
);

  localparam int MAXD = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW   = (MAXD > 2) ? $clog2(MAXD) : 1;
  localparam logic [CW-1:0] BLANK_LAST    = CW'(BLANK - 1);
  localparam logic [CW-1:0] PRESCALE_LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    sel_nx;
  logic          mux_en_nx;
  logic [3:0]    an_nx;
  logic          frame_nx;

  // First enabled digit strictly after cur, wrapping 3->0. If only cur is
  // enabled the search comes all the way round and returns cur itself.
  // Starting from cur=3 this yields the lowest enabled digit.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    // Descending scan so the nearest candidate is the last one written.
    for (int i = 4; i >= 1; i--) begin
      c = cur + 2'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic [3:0] an_of(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sel_nx    = sel;
    mux_en_nx = 1'b0;
    an_nx     = 4'hF;
    frame_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && (mask != 4'h0)) begin
          state_nx  = S_BLANK;
          sel_nx    = next_sel(2'd3, mask);
          cnt_nx    = '0;
          mux_en_nx = 1'b1;
        end
      end
      S_BLANK: begin
        if (!run) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
          an_nx    = an_of(sel);
        end else begin
          // Mux keeps loading during blanking so its registered output
          // is settled before the anode switches on.
          cnt_nx    = cnt + 1'b1;
          mux_en_nx = 1'b1;
        end
      end
      S_SHOW: begin
        if (!run) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == PRESCALE_LAST) begin
          cnt_nx = '0;
          // mask only matters here, so mid-dwell changes never cut a dwell short
          if (mask == 4'h0) begin
            state_nx = S_IDLE;
          end else begin
            state_nx  = S_BLANK;
            sel_nx    = next_sel(sel, mask);
            mux_en_nx = 1'b1;
            frame_nx  = (sel_nx <= sel);
          end
        end else begin
          cnt_nx = cnt + 1'b1;
          an_nx  = an_of(sel);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel    <= 2'b00;
      mux_en <= 1'b0;
      an     <= 4'hF;
      frame  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel    <= sel_nx;
      mux_en <= mux_en_nx;
      an     <= an_nx;
      frame  <= frame_nx;
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - directed bench for scan_ctrl with PRESCALE=4, BLANK=2
module tb_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       mux_en;
  logic [3:0] an;
  logic       frame;

  int checks;
  int errors;

  scan_ctrl #(
    .PRESCALE(4),
    .BLANK   (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .mask  (mask),
    .sel   (sel),
    .mux_en(mux_en),
    .an    (an),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {sel, mux_en, an, frame}
  function automatic logic [7:0] obs();
    return {sel, mux_en, an, frame};
  endfunction

  // Expected bundle for a blanking or showing cycle of digit s.
  function automatic logic [7:0] exp_cyc(input logic [1:0] s, input logic blank_ph, input logic fr);
    logic [3:0] a;
    a = 4'hF;
    if (!blank_ph) a[s] = 1'b0;
    return {s, blank_ph, a, fr};
  endfunction

  function automatic logic [7:0] exp_idle(input logic [1:0] s);
    return {s, 1'b0, 4'hF, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge with run=1, then release; the next tick is scan cycle 0.
  task automatic do_reset(input logic [3:0] m);
    rst  = 1'b1;
    run  = 1'b1;
    mask = m;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    run  = 1'b1;
    mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== exp_idle(2'd0)) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b expected=%b", i, obs(), exp_idle(2'd0));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_four_digits();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] e;
    do_reset(4'hF);
    for (int k = 0; k < 30; k++) begin
      tick();
      e = exp_cyc(seq[k / 6], (k % 6) < 2, k == 24);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL four_digits k=%0d got=%b expected=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_mask_1010();
    logic [1:0] seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [7:0] e;
    do_reset(4'b1010);
    for (int k = 0; k < 24; k++) begin
      tick();
      e = exp_cyc(seq[k / 6], (k % 6) < 2, k == 12);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL mask_1010 k=%0d got=%b expected=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_single_digit();
    logic [7:0] e;
    do_reset(4'b0100);
    for (int k = 0; k < 18; k++) begin
      tick();
      e = exp_cyc(2'd2, (k % 6) < 2, (k == 6) || (k == 12));
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL single_digit k=%0d got=%b expected=%b", k, obs(), e);
      end
    end
  endtask

  task automatic test_run_drop();
    do_reset(4'hF);
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (obs() !== exp_cyc(2'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL run_drop_pre got=%b expected=%b", obs(), exp_cyc(2'd1, 1'b0, 1'b0));
    end
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs() !== exp_idle(2'd1)) begin
        errors++;
        $display("FAIL run_drop_idle cyc=%0d got=%b expected=%b", i, obs(), exp_idle(2'd1));
      end
    end
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs() !== exp_cyc(2'd0, k < 2, 1'b0)) begin
        errors++;
        $display("FAIL run_restart k=%0d got=%b expected=%b", k, obs(), exp_cyc(2'd0, k < 2, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset(4'hF);
    for (int k = 0; k < 16; k++) tick();
    checks++;
    if (obs() !== exp_cyc(2'd2, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL rst_mid_show_pre got=%b expected=%b", obs(), exp_cyc(2'd2, 1'b0, 1'b0));
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== exp_idle(2'd0)) begin
      errors++;
      $display("FAIL rst_mid_show got=%b expected=%b", obs(), exp_idle(2'd0));
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== exp_cyc(2'd0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL rst_release_blank got=%b expected=%b", obs(), exp_cyc(2'd0, 1'b1, 1'b0));
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== exp_idle(2'd0)) begin
      errors++;
      $display("FAIL rst_mid_blank got=%b expected=%b", obs(), exp_idle(2'd0));
    end
    rst = 1'b0;
  endtask

  task automatic test_mask_zero();
    do_reset(4'hF);
    for (int k = 0; k < 9; k++) tick();
    mask = 4'h0;
    for (int k = 9; k < 12; k++) begin
      tick();
      checks++;
      if (obs() !== exp_cyc(2'd1, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL mask_zero_dwell k=%0d got=%b expected=%b", k, obs(), exp_cyc(2'd1, 1'b0, 1'b0));
      end
    end
    for (int k = 12; k < 14; k++) begin
      tick();
      checks++;
      if (obs() !== exp_idle(2'd1)) begin
        errors++;
        $display("FAIL mask_zero_idle k=%0d got=%b expected=%b", k, obs(), exp_idle(2'd1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    run    = 1'b0;
    mask   = 4'h0;
    test_reset();
    test_four_digits();
    test_mask_1010();
    test_single_digit();
    test_run_drop();
    test_reset_mid_scan();
    test_mask_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000: SHOW dwell per digit in clk cycles; legal range >=2.
REQ-002 Parameter BLANK, default 16: blanking cycles between digits; legal range >=2.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  scan enable; level-sensitive.
REQ-006 mask  input  4  digit enable mask; bit i=1 puts digit i in the scan.
REQ-007 sel  output  2  digit select, drives the 4:1 display mux sel.
REQ-008 mux_en  output  1  load enable, drives the display mux en.
REQ-009 an  output  4  anode drive, active-low, at most one bit low.
REQ-010 frame  output  1  one-cycle pulse on scan wrap-around.
REQ-011 All outputs SHALL be registered.

Function
REQ-012 FSM states SHALL be IDLE, BLANK and SHOW; a dwell counter SHALL be wide enough for max(PRESCALE,BLANK)-1.
REQ-013 IDLE: an=1111 and mux_en=0; sel SHALL hold its value.
REQ-014 IDLE->BLANK SHALL occur when run=1 and mask!=0; sel SHALL load the lowest set bit index of mask; counter=0; frame SHALL stay 0.
REQ-015 BLANK: an=1111 and mux_en=1; the mux therefore loads the data for sel before the anode turns on, which covers the mux's 1-cycle registered latency.
REQ-016 BLANK SHALL last exactly BLANK cycles; on the cycle counter==BLANK-1 the FSM SHALL move to SHOW with counter=0.
REQ-017 SHOW: mux_en=0; an[sel]=0 and all other an bits=1.
REQ-018 SHOW SHALL last exactly PRESCALE cycles; at counter==PRESCALE-1 the advance step SHALL run.
REQ-019 Advance step, state moves to BLANK:
  - mask is sampled at this step only;
  - sel = next set bit of mask above the current sel, in ascending order, wrapping 3->0;
  - if the search wraps, i.e. the new sel <= the old sel, frame=1 for that one cycle, coinciding with the first BLANK cycle.
REQ-020 Advance with a single-bit mask SHALL reselect the same digit and pulse frame on every advance.
REQ-021 Advance with mask==0 SHALL go to IDLE with an=1111 and mux_en=0, and SHALL NOT pulse frame.
REQ-022 Mask changes mid-dwell SHALL NOT cut the current BLANK or SHOW short, even when the current digit's bit is cleared.
REQ-023 run=0 sampled in BLANK or SHOW SHALL force IDLE on the next cycle:
  - an=1111, mux_en=0, frame=0, counter=0;
  - a later restart SHALL begin at the lowest enabled digit.
REQ-024 Full scan period with k enabled digits SHALL be k*(PRESCALE+BLANK) cycles.

Reset
REQ-025 rst=1 at a clock edge SHALL set: state=IDLE, sel=00, mux_en=0, an=1111, frame=0, counter=0.
REQ-026 rst SHALL take priority over run and mask in every state, including mid-SHOW and mid-BLANK.
REQ-027 After rst deasserts with run=1 and mask!=0, the first BLANK SHALL begin one cycle later.

Verification (PRESCALE=4, BLANK=2)
REQ-028 rst held 3 cycles, run=1, mask=1111 -> during reset sel=00, mux_en=0, an=1111, frame=0.
REQ-029 Release rst with mask=1111, run=1 -> sel sequence 0,1,2,3,0:
  - each digit: 2 cycles an=1111 with mux_en=1, then 4 cycles an=1110/1101/1011/0111;
  - frame high only on the first BLANK cycle of the 3->0 wrap;
  - period 24 cycles.
REQ-030 mask=1010 -> sel alternates 1,3; an 1101 then 0111; frame at each 3->1 wrap; period 12 cycles.
REQ-031 mask=0100 -> sel stays 2; an=1011 for 4 of every 6 cycles; frame every 6 cycles.
REQ-032 Drop run in cycle 2 of the SHOW for digit 1 -> next cycle an=1111, mux_en=0, IDLE; reassert run -> restart at digit 0.
REQ-033 Two scenarios:
  - pulse rst mid-SHOW -> reset values next cycle;
  - set mask=0000 mid-SHOW -> the dwell completes, then IDLE with no frame pulse.
